// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple slice. Also exposes the carry into the
// slice's top bit so the caller can derive signed overflow on the last slice.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  // Carry into the top bit is recovered from the top-bit sum, so CHUNK=1 works too.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum   = full[CHUNK-1:0];
    cout  = full[CHUNK];
    c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement add/sub, one CHUNK-bit slice per clock.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | one slice per edge, low slice first, ready=0
// DONE  | one-cycle done pulse, ready=1, start accepted back-to-back
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] b_reg,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("addsub_seq: CHUNK must divide WIDTH");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     acc;
  logic                 carry;
  logic [CW-1:0]        count;

  logic [CHUNK-1:0]     s_chunk;
  logic                 c_out;
  logic                 c_msb;
  logic [WIDTH+CHUNK-1:0] acc_wide;
  logic [WIDTH-1:0]     acc_next;
  logic                 last;

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_sh[CHUNK-1:0]),
    .b     (b_sh[CHUNK-1:0]),
    .cin   (carry),
    .sum   (s_chunk),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // New slice enters at the top of the working sum; after NCH slices it is aligned.
  always_comb begin
    acc_wide = {s_chunk, acc};
    acc_next = acc_wide[WIDTH+CHUNK-1:CHUNK];
    last     = (count == CW'(NCH - 1));
  end

  // FSM, operand shifters, slice counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            a_sh  <= a_reg;
            b_sh  <= (op == OP_SUB) ? ~b_reg : b_reg;
            carry <= (op == OP_SUB) ? ~cin : cin;
            count <= '0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= c_out;
          count <= count + 1'b1;
          if (last) begin
            state <= DONE;
            ready <= 1'b1;
            done  <= 1'b1;
            count <= '0;
            sum   <= acc_next;
            cout  <= c_out;
            ovf   <= c_msb ^ c_out;
            zero  <= (acc_next == '0);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: driver pushes expected results computed
// from signed/unsigned integer arithmetic, monitor pops on every done pulse.
module tb_addsub_seq;

  localparam int W   = 32;
  localparam int C   = 8;
  localparam int NCH = W / C;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, op, cin;
  logic [31:0] a, b;
  logic ready, done, cout, ovf, zero;
  logic [31:0] sum;

  logic s16_start, s16_op, s16_cin, s16_ready, s16_done, s16_cout, s16_ovf, s16_zero;
  logic [15:0] s16_a, s16_b, s16_sum;
  logic s8_start, s8_op, s8_cin, s8_ready, s8_done, s8_cout, s8_ovf, s8_zero;
  logic [7:0] s8_a, s8_b, s8_sum;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cin(cin),
    .a_reg(a), .b_reg(b), .ready(ready), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset(reset), .start(s16_start), .op(s16_op), .cin(s16_cin),
    .a_reg(s16_a), .b_reg(s16_b), .ready(s16_ready), .done(s16_done), .sum(s16_sum),
    .cout(s16_cout), .ovf(s16_ovf), .zero(s16_zero));

  addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op), .cin(s8_cin),
    .a_reg(s8_a), .b_reg(s8_b), .ready(s8_ready), .done(s8_done), .sum(s8_sum),
    .cout(s8_cout), .ovf(s8_ovf), .zero(s8_zero));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true integer result of a+b+cin or a-b-cin.
  function automatic exp_t model(input logic o, input logic c, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    longint ux, uy, sx, sy, u, t;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      u = ux + uy + longint'(c);
      t = sx + sy + longint'(c);
      r.cout = (u >= 64'sd4294967296);
    end else begin
      u = ux - uy - longint'(c);
      t = sx - sy - longint'(c);
      r.cout = (u >= 0);
    end
    r.sum  = u[31:0];
    r.ovf  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    r.zero = (r.sum == 32'd0);
    r.acc_cyc = 0;
    return r;
  endfunction

  task automatic issue(input logic o, input logic c, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("issue_ready_timeout", 64'd0, 64'd1);
      return;
    end
    op = o; cin = c; a = x; b = y; start = 1'b1;
    e = model(o, c, x, y);
    e.acc_cyc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom); cin = 1'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("cout", 64'(cout), 64'(e.cout));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("latency", 64'(cyc - e.acc_cyc), 64'(NCH));
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    s16_start = 0; s16_op = 0; s16_cin = 0; s16_a = '0; s16_b = '0;
    s8_start = 0; s8_op = 0; s8_cin = 0; s8_a = '0; s8_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);

    issue(1'b0, 1'b0, 32'h5, 32'h3);
    for (int i = 0; i < NCH; i++) begin
      @(negedge clk);
      chk("ready_low_run", 64'(ready), 64'd0);
    end
    issue(1'b1, 1'b0, 32'h5, 32'h3);
    issue(1'b1, 1'b0, 32'h3, 32'h5);
    issue(1'b1, 1'b1, 32'h5, 32'h3);
    issue(1'b0, 1'b0, 32'h000000FF, 32'h1);
    issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'h1);
    issue(1'b0, 1'b0, 32'h7FFFFFFF, 32'h1);
    issue(1'b1, 1'b0, 32'h80000000, 32'h1);

    // start during RUN with other operands must be ignored
    issue(1'b0, 1'b1, 32'h12345678, 32'h11111111);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hDEADBEEF; b = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;

    // reset after two RUN edges: aborted op never completes
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    issue(1'b0, 1'b0, 32'hAAAA5555, 32'h1234);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_flags", 64'({cout, ovf, zero}), 64'd0);
    repeat (6) @(negedge clk);
    issue(1'b1, 1'b0, 32'h1, 32'h1);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h7FFFFFFF;
        1: y = 32'h80000000;
        2: y = x;
        default: ;
      endcase
      issue(1'($urandom), 1'($urandom), x, y);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_queue", 64'(q.size()), 64'd0);

    // WIDTH=16, CHUNK=4
    @(negedge clk);
    s16_op = 1'b1; s16_cin = 1'b0; s16_a = 16'h8000; s16_b = 16'h0001; s16_start = 1'b1;
    @(posedge clk);
    #1 s16_start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s16_done && n < 30);
    chk("w16_latency", 64'(n - 1), 64'd4);
    chk("w16_sum", 64'(s16_sum), 64'h7FFF);
    chk("w16_ovf", 64'(s16_ovf), 64'd1);
    chk("w16_cout", 64'(s16_cout), 64'd1);

    // WIDTH=8, CHUNK=8
    @(negedge clk);
    s8_op = 1'b0; s8_cin = 1'b0; s8_a = 8'h80; s8_b = 8'h80; s8_start = 1'b1;
    @(posedge clk);
    #1 s8_start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s8_done && n < 30);
    chk("w8_latency", 64'(n - 1), 64'd1);
    chk("w8_sum", 64'(s8_sum), 64'h00);
    chk("w8_flags", 64'({s8_cout, s8_ovf, s8_zero}), 64'b111);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Next generation of the fixed 32-bit combinational add/sub blocks.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock. Uses a start/ready/done handshake.
- Adds signed-overflow and zero flags. Subtraction is a correct a - b - borrow, formed as a + ~b + ~cin.
- Sits beside the ALU datapath where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH. NCH = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- op  input  1  0 = add (a + b + cin), 1 = subtract (a - b - cin).
- cin  input  1  carry-in (add) or borrow-in (sub).
- a_reg  input  WIDTH  operand A; sampled on the accepting edge.
- b_reg  input  WIDTH  operand B; sampled on the accepting edge.
- ready  output  1  block can accept start this cycle.
- done  output  1  one-cycle pulse: sum/cout/ovf/zero are valid.
- sum  output  WIDTH  result.
- cout  output  1  add: carry out. Sub: 1 = no borrow, 0 = borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state IDLE, ready=1, done=0, sum=0, cout=0, ovf=0, zero=0; internal counter and carry are 0.
- States:
  - IDLE: ready=1. start=1 → RUN. Latch A; latch B, or ~B when op=1. Carry register = cin when op=0, ~cin when op=1. count=0.
  - RUN: ready=0. Each edge adds slice[count] of A and B plus the carry register. Writes sum slice[count], updates the carry register, count++. On the edge processing slice NCH-1 → DONE.
  - DONE: done=1, ready=1. start=1 → RUN (back-to-back, same rules as IDLE); otherwise → IDLE.
- Latency: accepting edge E0; slices processed at E1..E_NCH; done=1 for the cycle after E_NCH. Peak throughput is one op per NCH+1 cycles.
- Flags, registered on the E_NCH edge:
  - cout = carry out of the MSB.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - zero = (full sum == 0).
- Output hold: sum/cout/ovf/zero hold their values after done until the next accepted op's E_NCH edge. They are not cleared on accept.
- start while ready=0: ignored. No queuing, no error.
- Operand changes after E0 have no effect.
- reset asserted mid-RUN: abort at that edge. All outputs return to reset values; done is not pulsed.
- reset and start in the same cycle: reset wins.
- NCH=1 is legal: done follows E1.
- WIDTH % CHUNK != 0 is illegal. Flag it with an elaboration-time check.

Decomposition:
- Package addsub_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module add_chunk (parametrised CHUNK): combinational.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into the top bit, used for ovf).
- The top module holds the FSM, counter, operand shift/index logic and result registers.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
1. op=0, a=0x00000005, b=0x00000003, cin=0 → done exactly 4 edges after accept. sum=0x00000008, cout=0, ovf=0, zero=0. ready low for the 4 RUN cycles.
2. Subtract:
   - op=1, 5-3, cin=0 → sum=0x00000002, cout=1.
   - 3-5 → sum=0xFFFFFFFE, cout=0.
   - 5-3 with cin=1 → sum=0x00000001.
3. Cross-chunk carry and flags:
   - 0x000000FF+1 → 0x00000100.
   - 0xFFFFFFFF+1 → sum=0, cout=1, zero=1.
   - 0x7FFFFFFF+1 → 0x80000000, ovf=1.
   - sub 0x80000000-1 → 0x7FFFFFFF, ovf=1.
4. Handshake:
   - start pulsed during RUN with different operands → ignored; first result unchanged.
   - start in the DONE cycle → accepted. Second done 5 cycles after the first.
5. Reset mid-op: reset after 2 RUN edges → next cycle ready=1, sum=0, all flags 0, no done pulse. A following op completes normally.
6. Re-parametrise:
   - WIDTH=16, CHUNK=4: 0x8000-0x0001 → 0x7FFF, ovf=1, done after 4 edges.
   - WIDTH=8, CHUNK=8: 0x80+0x80 → 0x00, cout=1, ovf=1, zero=1, done after 1 edge.
